// File: rtl/mul16_seq_if.sv
// Handshake and shared-adder bundle for the sequential 16x16 multiplier.
// The slave side is the multiplier. The master side is whoever issues
// multiplies and also provides the external ripple-carry adder's return path.
interface mul16_seq_if;
  logic        Start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] P;
  logic [15:0] AddA;
  logic [15:0] AddB;
  logic        AddCin;
  logic [15:0] AddSum;
  logic        AddCout;

  modport slave (
    input  Start, A, B, AddSum, AddCout,
    output Busy, Done, P, AddA, AddB, AddCin
  );

  modport master (
    output Start, A, B, AddSum, AddCout,
    input  Busy, Done, P, AddA, AddB, AddCin
  );
endinterface

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier controller.
// It borrows the core's external 16-bit adder and retires one partial
// product per clock. The adder carry-out shifts into the top of the
// accumulator, so the 32-bit product is always exact.
module mul16_seq (
  input  logic         clk,
  input  logic         rst,
  mul16_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] m_q;
  logic [15:0] acc_q;
  logic [15:0] q_q;
  logic [3:0]  cnt_q;
  logic [31:0] p_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] addA;
  logic [15:0] addB;
  logic        addCin;
  logic [15:0] acc_d;
  logic [15:0] q_d;

  // Drive the shared adder only while running and form the 33-bit right-shifted step result
  always_comb begin
    addA   = 16'h0000;
    addB   = 16'h0000;
    addCin = 1'b0;
    if (state_q == RUN) begin
      addA = acc_q;
      addB = q_q[0] ? m_q : 16'h0000;
    end
    acc_d = {bus.AddCout, bus.AddSum[15:1]};
    q_d   = {bus.AddSum[0], q_q[15:1]};
  end

  assign bus.AddA   = addA;
  assign bus.AddB   = addB;
  assign bus.AddCin = addCin;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.P      = p_q;

  // Control FSM and datapath registers; Busy/Done are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= 16'h0000;
      acc_q   <= 16'h0000;
      q_q     <= 16'h0000;
      cnt_q   <= 4'd0;
      p_q     <= 32'h0000_0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            m_q     <= bus.A;
            q_q     <= bus.B;
            acc_q   <= 16'h0000;
            cnt_q   <= 4'd0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          if (cnt_q == 4'd15) begin
            p_q     <= {acc_d, q_d};
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq. It supplies the external adder
// behaviourally and compares every product against plain A*B arithmetic.
// Handshake timing is checked against the fixed 17-cycle latency.
module tb_mul16_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mul16_seq_if bus ();

  mul16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock with a 10 time-unit period
  always #5 clk = ~clk;

  // Behavioural model of the shared ripple-carry adder
  assign {bus.AddCout, bus.AddSum} = 17'(bus.AddA) + 17'(bus.AddB) + 17'(bus.AddCin);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Runs one multiply starting from a negedge in IDLE and returns at the negedge after E17.
  // keepStart leaves Start high throughout, pulseIgnored fires stray Start pulses during
  // RUN and DONE, and zeroAddB checks that the adder sees no multiplicand on any step.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input string tag,
                               input bit keepStart, input bit pulseIgnored, input bit zeroAddB);
    logic [31:0] expected;
    expected  = 32'(a) * 32'(b);
    bus.Start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    if (!keepStart) bus.Start = 1'b0;
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
    for (int k = 1; k <= 16; k++) begin
      checkOutput({tag, "-busy"}, 32'(bus.Busy), 32'd1);
      checkOutput({tag, "-doneLowInRun"}, 32'(bus.Done), 32'd0);
      checkOutput({tag, "-cinInRun"}, 32'(bus.AddCin), 32'd0);
      if (zeroAddB) checkOutput({tag, "-addBZero"}, 32'(bus.AddB), 32'd0);
      if (pulseIgnored && k == 5) begin
        bus.Start = 1'b1;
        bus.A     = 16'hABCD;
        bus.B     = 16'h1357;
      end
      if (pulseIgnored && k == 6) bus.Start = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, "-doneHigh"}, 32'(bus.Done), 32'd1);
    checkOutput({tag, "-busyLowDone"}, 32'(bus.Busy), 32'd0);
    checkOutput({tag, "-product"}, bus.P, expected);
    checkOutput({tag, "-adderIdleDone"}, {15'd0, bus.AddCin, bus.AddA | bus.AddB}, 32'd0);
    if (pulseIgnored) begin
      bus.Start = 1'b1;
      bus.A     = 16'h2468;
      bus.B     = 16'h9999;
    end
    @(negedge clk);
    if (pulseIgnored) bus.Start = 1'b0;
    checkOutput({tag, "-doneLowAfter"}, 32'(bus.Done), 32'd0);
    checkOutput({tag, "-busyLowAfter"}, 32'(bus.Busy), 32'd0);
    checkOutput({tag, "-productHeld"}, bus.P, expected);
    checkOutput({tag, "-adderIdle"}, {15'd0, bus.AddCin, bus.AddA | bus.AddB}, 32'd0);
  endtask

  // Directed scenarios followed by the randomized sweep
  initial begin
    logic [15:0] ra;
    logic [15:0] rb;

    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.A     = 16'h0000;
    bus.B     = 16'h0000;
    repeat (2) @(negedge clk);
    checkOutput("reset-busy", 32'(bus.Busy), 32'd0);
    checkOutput("reset-done", 32'(bus.Done), 32'd0);
    checkOutput("reset-P", bus.P, 32'd0);
    checkOutput("reset-adder", {15'd0, bus.AddCin, bus.AddA | bus.AddB}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle-busy", 32'(bus.Busy), 32'd0);

    applyStimulus(16'h0003, 16'h0005, "basic", 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, "maxOps", 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h1234, 16'h0000, "zeroB", 1'b0, 1'b0, 1'b1);

    applyStimulus(16'h0101, 16'h0203, "ignoreStart", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("ignoreStart-noExtraDone", 32'(bus.Done), 32'd0);
      checkOutput("ignoreStart-noExtraBusy", 32'(bus.Busy), 32'd0);
      @(negedge clk);
    end

    bus.Start = 1'b1;
    bus.A     = 16'h7777;
    bus.B     = 16'h3333;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort-busy", 32'(bus.Busy), 32'd0);
    checkOutput("abort-done", 32'(bus.Done), 32'd0);
    checkOutput("abort-P", bus.P, 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("abort-noDone", 32'(bus.Done), 32'd0);
    end
    applyStimulus(16'h0010, 16'h0010, "afterAbort", 1'b0, 1'b0, 1'b0);

    bus.Start = 1'b1;
    rst       = 1'b1;
    bus.A     = 16'h0005;
    bus.B     = 16'h0005;
    @(negedge clk);
    checkOutput("rstStart-busy", 32'(bus.Busy), 32'd0);
    rst       = 1'b0;
    bus.Start = 1'b0;
    @(negedge clk);
    checkOutput("rstStart-notAccepted", 32'(bus.Busy), 32'd0);
    checkOutput("rstStart-P", bus.P, 32'd0);

    applyStimulus(16'h8000, 16'h0002, "b2b-first", 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h00FF, 16'h0101, "b2b-second", 1'b1, 1'b0, 1'b0);
    applyStimulus(16'hC001, 16'hFFFE, "b2b-third", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      applyStimulus(ra, rb, "random", 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    bus.Start = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
